parity_frame_rx: RTL and testbench
==================================

Name: parity_frame_rx

Overview:
- Receiving end of the team's even-parity link: a serial frame receiver that checks the parity bit produced by the transmit-side parity generator.
- Deserialises one bit per clock into a WIDTH-bit word, checks parity and stop bit, and presents the word on a valid/ready output buffer with error flags.
- Sits between the serial pin and word-level consumer logic.

Parameters:
- WIDTH, 8, number of data bits per frame (>=1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- sin  input  1  serial line; idles high; one bit per clk cycle.
- out_data  output  WIDTH  received word.
- out_valid  output  1  out_data/flags hold a frame.
- out_ready  input  1  consumer accepts the frame when out_valid && out_ready.
- par_err  output  1  parity mismatch for the frame in the buffer.
- frm_err  output  1  stop bit was 0 for the frame in the buffer.
- ovr  output  1  sticky overrun flag.
- ovr_clr  input  1  clears ovr.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE; out_data=0; out_valid=0; par_err=0; frm_err=0; ovr=0; bit counter=0.
  - Reset mid-frame aborts the frame and discards partial data.
- Frame format on sin: start bit (0), WIDTH data bits LSB first, parity bit, stop bit (1). Total WIDTH+3 cycles.
- Parity is even: the transmitter sends p = ^data. The check is par_err_new = (^data) ^ p.
- FSM states:
  - IDLE: sin==0 at an edge -> DATA, counter=0. Otherwise stay.
  - DATA: shift sin into the shift register at position counter; counter+1. After WIDTH bits -> PARITY.
  - PARITY: capture p -> STOP.
  - STOP: sample stop bit, set frm_err_new = ~sin, then commit (see below) -> IDLE.
- Back-to-back frames are allowed: a start bit on the cycle immediately after STOP is accepted.
- A stop bit of 0 is not treated as a new start bit; the receiver returns to IDLE first.
- Commit at the STOP edge:
  - If the buffer is free, or is being drained the same cycle (out_valid && out_ready): load out_data, par_err, frm_err; out_valid=1 from the next cycle.
  - If the buffer is full and not being drained: new frame dropped, buffer unchanged, ovr<=1.
- Frames with errors are still delivered, flagged.
- Handshake:
  - out_valid && out_ready with no commit in the same cycle -> out_valid<=0 next cycle.
  - Buffer contents hold stable while out_valid && !out_ready.
- Latency: out_valid rises 1 cycle after the stop bit is sampled, i.e. WIDTH+3 cycles after the start bit is sampled.
- ovr: set as above; cleared by ovr_clr. If set and clear occur in the same cycle, set wins.
- Counter width is $clog2(WIDTH+1); there is no wrap inside a frame.

Optional Feature:
- Macro: PARITY_RX_GRAY_DECODE_EN.
- Defined: the received word is treated as Gray code and converted to binary before it is loaded into out_data: b[WIDTH-1]=g[WIDTH-1], b[i]=b[i+1]^g[i]. Parity is checked on the raw Gray bits as received. Latency unchanged.
- Undefined: out_data is the raw received bits.

Test Plan:
- Reset, then sin held 1 for 20 cycles -> out_valid=0, ovr=0, all outputs 0.
- WIDTH=8, frame 0xA5: bits 0,1,0,1,0,0,1,0,1, parity 0, stop 1, out_ready=1 -> out_valid for 1 cycle, out_data=0xA5 (0xC6 with PARITY_RX_GRAY_DECODE_EN), par_err=0, frm_err=0.
- Frame 0x01 with parity bit 0 -> out_data=0x01, par_err=1. Frame 0x3C with stop bit 0 -> frm_err=1, par_err=0.
- out_ready=0, send 0x11 then 0x22 back-to-back -> out_data stays 0x11, ovr=1. Raise out_ready -> 0x11 accepted; ovr stays 1 until ovr_clr.
- Stream all 256 Gray codes (counter^(counter>>1)) back-to-back with correct parity, out_ready=1 -> 256 valid frames, zero errors; with PARITY_RX_GRAY_DECODE_EN, out_data equals 0..255 in order.
- Assert rst during the DATA state of a frame -> next cycle all outputs 0, state IDLE; a following clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/parity_frame_rx_if.sv
//
// parity_frame_rx_if
// ------------------
// Purpose: bundles the serial line, the word-level output buffer handshake,
// the error flags and the overrun controls of the even-parity frame receiver
// into one connection.
//
// Parameters:
//   WIDTH      number of data bits per frame
//
// Signals:
//   sin        serial line into the receiver (idles high)
//   out_data   received word held in the output buffer
//   out_valid  output buffer holds a frame
//   out_ready  consumer accepts the frame when out_valid && out_ready
//   par_err    parity mismatch for the buffered frame
//   frm_err    stop bit was 0 for the buffered frame
//   ovr        sticky overrun flag
//   ovr_clr    clears ovr
//
// Modports:
//   slave      receiver side (consumes sin, produces the buffer and flags)
//   master     environment side (drives sin, consumes the buffer and flags)

interface parity_frame_rx_if #(
    parameter int WIDTH = 8
);
    logic             sin;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             par_err;
    logic             frm_err;
    logic             ovr;
    logic             ovr_clr;

    modport slave (
        input  sin,
        input  out_ready,
        input  ovr_clr,
        output out_data,
        output out_valid,
        output par_err,
        output frm_err,
        output ovr
    );

    modport master (
        output sin,
        output out_ready,
        output ovr_clr,
        input  out_data,
        input  out_valid,
        input  par_err,
        input  frm_err,
        input  ovr
    );
endinterface

// File: rtl/parity_frame_rx.sv
//
// parity_frame_rx
// ---------------
// Purpose: receiving end of the even-parity serial link. It deserialises one
// bit per clock into a WIDTH-bit word, checks the parity bit and the stop bit,
// and presents the word with its error flags on a single-entry valid/ready
// output buffer. A frame that completes while the buffer is full and not being
// drained is dropped, and the sticky overrun flag is raised.
//
// Frame on sin: start bit (0), WIDTH data bits LSB first, even parity bit,
// stop bit (1).
//
// Parameters:
//   WIDTH      number of data bits per frame (>= 1)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   bus        parity_frame_rx_if.slave: sin, out_data, out_valid, out_ready,
//              par_err, frm_err, ovr, ovr_clr
//
// Optional build macro:
//   PARITY_RX_GRAY_DECODE_EN  when defined, the received word is treated as
//                             Gray code and converted to binary before it is
//                             loaded into out_data; parity is still checked on
//                             the raw received bits.

module parity_frame_rx #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    parity_frame_rx_if.slave    bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [WIDTH-1:0] outData_q, outData_d;
    logic             outValid_q, outValid_d;
    logic             parErr_q, parErr_d;
    logic             frmErr_q, frmErr_d;
    logic             ovr_q, ovr_d;

    logic [WIDTH-1:0] rxWord;
    logic             drain;
    logic             ovrSet;

`ifdef PARITY_RX_GRAY_DECODE_EN
    // Gray to binary: each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [WIDTH-1:0] grayToBin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b            = '0;
        b[WIDTH-1]   = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign rxWord = grayToBin(shift_q);
`else
    assign rxWord = shift_q;
`endif

    // The buffer is being emptied this cycle, which also frees it for a commit.
    assign drain = outValid_q && bus.out_ready;

    // Next-state logic for the frame FSM, the output buffer and the overrun flag.
    // A completed frame is committed at the STOP edge when the buffer is free or
    // draining; otherwise it is dropped and ovr is raised. A set of ovr takes
    // priority over a simultaneous clear.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        outData_d  = outData_q;
        outValid_d = outValid_q;
        parErr_d   = parErr_q;
        frmErr_d   = frmErr_q;
        ovr_d      = ovr_q;
        ovrSet     = 1'b0;

        if (drain) begin
            outValid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!bus.sin) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (cnt_q == CW'(i)) begin
                        shift_d[i] = bus.sin;
                    end
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                parity_d = bus.sin;
                state_d  = STOP;
            end
            STOP: begin
                // A low stop bit is flagged, never reused as the next start bit.
                state_d = IDLE;
                if (!outValid_q || drain) begin
                    outData_d  = rxWord;
                    parErr_d   = (^shift_q) ^ parity_q;
                    frmErr_d   = ~bus.sin;
                    outValid_d = 1'b1;
                end else begin
                    ovrSet = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (ovrSet) begin
            ovr_d = 1'b1;
        end else if (bus.ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    // State register; reset aborts any frame in progress and empties the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            parErr_q   <= 1'b0;
            frmErr_q   <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
            parErr_q   <= parErr_d;
            frmErr_q   <= frmErr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign bus.out_data  = outData_q;
    assign bus.out_valid = outValid_q;
    assign bus.par_err   = parErr_q;
    assign bus.frm_err   = frmErr_q;
    assign bus.ovr       = ovr_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
//
// tb_parity_frame_rx
// ------------------
// Purpose: self-checking bench for parity_frame_rx with WIDTH = 8. Serial
// frames are driven on the falling edge; every accepted output word is logged
// by a monitor and compared against expectations computed from the frame
// format (population count for parity, prefix XOR for Gray decoding).
//
// Build macro honoured: PARITY_RX_GRAY_DECODE_EN (expected words follow it).

module tb_parity_frame_rx;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    parity_frame_rx_if #(.WIDTH(W)) bus ();

    parity_frame_rx #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Accepted frames as {word, par_err, frm_err}.
    logic [W+1:0] got[$];
    logic [W+1:0] exp[$];

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Inputs only change on the falling edge, so one unit later the values the
    // next rising edge will act on are settled; log every accepted frame there.
    always begin
        @(negedge clk);
        #1;
        if (!rst && bus.out_valid && bus.out_ready) begin
            got.push_back({bus.out_data, bus.par_err, bus.frm_err});
        end
    end

    // Hard stop in case something never returns.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // ---------------- reference model ----------------

    function automatic logic [W-1:0] modelWord(input logic [W-1:0] g);
`ifdef PARITY_RX_GRAY_DECODE_EN
        logic [W-1:0] b;
        b = '0;
        for (int s = 0; s < W; s++) begin
            b = b ^ (g >> s);
        end
        return b;
`else
        return g;
`endif
    endfunction

    function automatic logic evenBit(input logic [W-1:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    function automatic logic [W+1:0] modelFrame(input logic [W-1:0] d, input logic p,
                                                input logic stop);
        return {modelWord(d), (evenBit(d) != p), ~stop};
    endfunction

    // ---------------- stimulus helpers ----------------

    task automatic sendBit(input logic b);
        @(negedge clk);
        bus.sin = b;
    endtask

    task automatic sendFrame(input logic [W-1:0] d, input logic p, input logic stop);
        sendBit(1'b0);
        for (int i = 0; i < W; i++) begin
            sendBit(d[i]);
        end
        sendBit(p);
        sendBit(stop);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            sendBit(1'b1);
        end
    endtask

    // Idles the line until the monitor has logged a frame, bounded.
    task automatic waitFrame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            bus.sin = 1'b1;
            #2;
            if (got.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        rst           = 1'b1;
        bus.sin       = 1'b1;
        bus.out_ready = 1'b1;
        bus.ovr_clr   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(20);
        #2;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_out_data: got %h expected 00", bus.out_data);
        end
        checks++;
        if (bus.par_err !== 1'b0 || bus.frm_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got par=%b frm=%b expected 0 0",
                     bus.par_err, bus.frm_err);
        end
        checks++;
        if (bus.ovr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ovr: got %b expected 0", bus.ovr);
        end
        checks++;
        if (got.size() != 0) begin
            errors++;
            $display("[TB] FAIL reset_no_frames: got %0d frames expected 0", got.size());
        end
    endtask

    task automatic test_frames();
        logic [W-1:0] dTab[3]    = '{8'hA5, 8'h01, 8'h3C};
        logic         pTab[3]    = '{1'b0, 1'b0, 1'b0};
        logic         sTab[3]    = '{1'b1, 1'b1, 1'b0};
        logic [W+1:0] f;
        logic [W-1:0] a5Word;
        bit           ok;
`ifdef PARITY_RX_GRAY_DECODE_EN
        a5Word = 8'hC6;
`else
        a5Word = 8'hA5;
`endif
        for (int k = 0; k < 3; k++) begin
            got.delete();
            sendFrame(dTab[k], pTab[k], sTab[k]);
            waitFrame(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL frame%0d_timeout: got no frame expected one", k);
            end else begin
                f = got.pop_front();
                checks++;
                if (f !== modelFrame(dTab[k], pTab[k], sTab[k])) begin
                    errors++;
                    $display("[TB] FAIL frame%0d_content: got %h expected %h", k, f,
                             modelFrame(dTab[k], pTab[k], sTab[k]));
                end
                if (k == 0) begin
                    checks++;
                    if (f[W+1:2] !== a5Word) begin
                        errors++;
                        $display("[TB] FAIL frame_a5_word: got %h expected %h",
                                 f[W+1:2], a5Word);
                    end
                end
                @(negedge clk);
                #2;
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL frame%0d_single_cycle: got out_valid %b expected 0",
                             k, bus.out_valid);
                end
            end
        end
    endtask

    task automatic test_overrun();
        logic [W+1:0] f;
        bit           ok;
        @(negedge clk);
        bus.out_ready = 1'b0;
        got.delete();
        sendFrame(8'h11, evenBit(8'h11), 1'b1);
        sendFrame(8'h22, evenBit(8'h22), 1'b1);
        idle(3);
        #2;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== modelWord(8'h11)) begin
            errors++;
            $display("[TB] FAIL ovr_hold: got valid=%b data=%h expected 1 %h",
                     bus.out_valid, bus.out_data, modelWord(8'h11));
        end
        checks++;
        if (bus.ovr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovr_set: got %b expected 1", bus.ovr);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        waitFrame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL ovr_drain_timeout: got no frame expected one");
        end else begin
            f = got.pop_front();
            checks++;
            if (f !== modelFrame(8'h11, evenBit(8'h11), 1'b1)) begin
                errors++;
                $display("[TB] FAIL ovr_drain_word: got %h expected %h", f,
                         modelFrame(8'h11, evenBit(8'h11), 1'b1));
            end
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ovr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovr_sticky: got valid=%b ovr=%b expected 0 1",
                     bus.out_valid, bus.ovr);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.ovr_clr   = 1'b1;
        @(negedge clk);
        bus.ovr_clr   = 1'b0;
        #2;
        checks++;
        if (bus.ovr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovr_clear: got %b expected 0", bus.ovr);
        end

        // Overrun arriving while the clear is held: the set must win.
        sendFrame(8'h33, evenBit(8'h33), 1'b1);
        idle(1);
        bus.ovr_clr = 1'b1;
        sendFrame(8'h44, evenBit(8'h44), 1'b1);
        @(negedge clk);
        bus.ovr_clr = 1'b0;
        bus.sin     = 1'b1;
        #2;
        checks++;
        if (bus.ovr !== 1'b1 || bus.out_data !== modelWord(8'h33)) begin
            errors++;
            $display("[TB] FAIL ovr_set_wins: got ovr=%b data=%h expected 1 %h",
                     bus.ovr, bus.out_data, modelWord(8'h33));
        end
        got.delete();
        @(negedge clk);
        bus.out_ready = 1'b1;
        waitFrame(ok);
        checks++;
        if (!ok || got[0] !== modelFrame(8'h33, evenBit(8'h33), 1'b1)) begin
            errors++;
            $display("[TB] FAIL ovr_second_drain: got %h expected %h",
                     ok ? got[0] : '0, modelFrame(8'h33, evenBit(8'h33), 1'b1));
        end
        @(negedge clk);
        bus.ovr_clr = 1'b1;
        @(negedge clk);
        bus.ovr_clr = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        logic         p;
        logic         stop;
        int           gap;
        int           n;
        got.delete();
        exp.delete();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            d    = W'($urandom_range(0, 255));
            p    = evenBit(d) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            gap  = $urandom_range(0, 2);
            sendFrame(d, p, stop);
            exp.push_back(modelFrame(d, p, stop));
            idle(gap);
        end
        idle(15);
        checks++;
        if (got.size() != exp.size()) begin
            errors++;
            $display("[TB] FAIL random_count: got %0d frames expected %0d",
                     got.size(), exp.size());
        end
        n = (got.size() < exp.size()) ? got.size() : exp.size();
        for (int k = 0; k < n; k++) begin
            checks++;
            if (got[k] !== exp[k]) begin
                errors++;
                $display("[TB] FAIL random_frame%0d: got %h expected %h", k, got[k], exp[k]);
            end
        end
        checks++;
        if (bus.ovr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL random_ovr: got %b expected 0", bus.ovr);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] g;
        logic [W-1:0] want;
        got.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            g = W'(i ^ (i >> 1));
            sendFrame(g, evenBit(g), 1'b1);
        end
        idle(15);
        checks++;
        if (got.size() != 256) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d frames expected 256", got.size());
        end
        for (int i = 0; i < got.size() && i < 256; i++) begin
`ifdef PARITY_RX_GRAY_DECODE_EN
            want = W'(i);
`else
            want = W'(i ^ (i >> 1));
`endif
            checks++;
            if (got[i] !== {want, 2'b00}) begin
                errors++;
                $display("[TB] FAIL b2b_frame%0d: got %h expected %h", i, got[i],
                         {want, 2'b00});
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        @(negedge clk);
        bus.out_ready = 1'b0;
        sendFrame(8'h77, evenBit(8'h77), 1'b1);
        sendFrame(8'h66, evenBit(8'h66), 1'b1);
        idle(2);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        @(negedge clk);
        rst     = 1'b1;
        bus.sin = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.par_err !== 1'b0 ||
            bus.frm_err !== 1'b0 || bus.ovr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got valid=%b data=%h par=%b frm=%b ovr=%b expected all 0",
                     bus.out_valid, bus.out_data, bus.par_err, bus.frm_err, bus.ovr);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        got.delete();
        idle(3);
        checks++;
        if (got.size() != 0) begin
            errors++;
            $display("[TB] FAIL midreset_spurious: got %0d frames expected 0", got.size());
        end
        sendFrame(8'h5A, evenBit(8'h5A), 1'b1);
        waitFrame(ok);
        checks++;
        if (!ok || got[0] !== modelFrame(8'h5A, evenBit(8'h5A), 1'b1)) begin
            errors++;
            $display("[TB] FAIL midreset_next_frame: got %h expected %h",
                     ok ? got[0] : '0, modelFrame(8'h5A, evenBit(8'h5A), 1'b1));
        end
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_frames();
        test_overrun();
        test_random();
        test_back_to_back();
        test_reset_mid();
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
